shadow_reg_wr_ctrl: RTL

Arbitrated write sequencer for banks of shadowed register slices (`prim_subreg_shadow` instances). It accepts single-shot write requests from `NumReq` hardware requesters and shares one shadow bank port between them with round-robin arbitration. For each request it runs the full shadow protocol: a phase-clearing read, then two identical writes. It checks the update-error flag on the second write, retries on error, reports per-requester completion, and raises a sticky alert on storage errors.

---
 rtl/shadow_reg_wr_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/shadow_reg_wr_ctrl.sv
// Round-robin write sequencer for shadowed register banks: for each granted request it
// runs a phase-clearing read followed by two identical writes, retrying on update errors.
module shadow_reg_wr_ctrl #(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 4,
    parameter int unsigned MaxRetry = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumReq-1:0]    req_i,
    input  logic [NumReq*AW-1:0] addr_i,
    input  logic [NumReq*DW-1:0] wdata_i,
    output logic [NumReq-1:0]    gnt_o,
    output logic [NumReq-1:0]    done_o,
    output logic                 resp_err_o,
    output logic                 re_o,
    output logic                 we_o,
    output logic [AW-1:0]        addr_o,
    output logic [DW-1:0]        wd_o,
    input  logic                 err_update_i,
    input  logic                 err_storage_i,
    output logic                 alert_o,
    output logic [2:0]           dbg_state_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_WR0   = 3'd2,
        ST_WR1   = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    state_e            r_state;
    logic [IdxW-1:0]   r_idx;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata;
    logic [1:0]        r_retry;
    logic              r_err;
    logic [IdxW-1:0]   r_last;
    logic              r_alert;

    state_e            w_state;
    logic [IdxW-1:0]   w_idx;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_wdata;
    logic [1:0]        w_retry;
    logic              w_err;
    logic [IdxW-1:0]   w_last;
    logic              w_alert;

    logic              w_win_valid;
    logic [IdxW-1:0]   w_win_idx;
    logic [NumReq-1:0] w_gnt;
    logic [NumReq-1:0] w_done;
    logic              w_resp_err;
    logic              w_re;
    logic              w_we;

    // Scan from the farthest offset down so the nearest requester after r_last wins.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        for (int off = NumReq; off >= 1; off--) begin
            if (req_i[(int'(r_last) + off) % NumReq]) begin
                w_win_valid = 1'b1;
                w_win_idx   = IdxW'((int'(r_last) + off) % NumReq);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_retry <= '0;
            r_err   <= 1'b0;
            r_last  <= IdxW'(NumReq - 1);
            r_alert <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_retry <= w_retry;
            r_err   <= w_err;
            r_last  <= w_last;
            r_alert <= w_alert;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_retry    = r_retry;
        w_err      = r_err;
        w_last     = r_last;
        w_alert    = r_alert | err_storage_i;
        w_gnt      = '0;
        w_done     = '0;
        w_resp_err = 1'b0;
        w_re       = 1'b0;
        w_we       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_gnt[w_win_idx] = 1'b1;
                    w_idx            = w_win_idx;
                    w_addr           = addr_i[w_win_idx*AW +: AW];
                    w_wdata          = wdata_i[w_win_idx*DW +: DW];
                    w_retry          = '0;
                    w_err            = 1'b0;
                    w_state          = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_re    = 1'b1;
                w_state = ST_WR0;
            end
            ST_WR0: begin
                w_we    = 1'b1;
                w_state = ST_WR1;
            end
            ST_WR1: begin
                w_we = 1'b1;
                // The commit write is the one that reports a mismatch between the two phases.
                if (err_update_i) begin
                    if (r_retry < 2'(MaxRetry)) begin
                        w_retry = r_retry + 2'd1;
                        w_state = ST_CLEAR;
                    end else begin
                        w_err   = 1'b1;
                        w_state = ST_RESP;
                    end
                end else begin
                    w_err   = 1'b0;
                    w_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_done[r_idx] = 1'b1;
                w_resp_err    = r_err;
                w_last        = r_idx;
                w_state       = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // Grant is combinational from req_i, so hold it low while reset is asserted.
    assign gnt_o       = rst_ni ? w_gnt : '0;
    assign done_o      = w_done;
    assign resp_err_o  = w_resp_err;
    assign re_o        = w_re;
    assign we_o        = w_we;
    assign addr_o      = (r_state != ST_IDLE) ? r_addr : '0;
    assign wd_o        = (r_state != ST_IDLE) ? r_wdata : '0;
    assign alert_o     = r_alert;
    assign dbg_state_o = r_state;

endmodule
